// File: rtl/pc_fetch_pkg.sv
// Shared constants and the fetch/decode register payload for the fetch stage.
// Optional feature macro: PC_MISALIGN_TRAP_EN (trap misaligned redirect targets).
package pc_fetch_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
    } fetch_dec_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Control-unit <-> fetch-stage bundle. master = control unit side, slave = fetch stage.
// Optional feature macro: PC_MISALIGN_TRAP_EN adds the oMisaligned pulse.
interface pc_fetch_if #(
    parameter int unsigned CNT_W = 16
);

    logic             iPCsrc;
    logic [31:0]      iImmExt;
    logic             iStall;
    logic             iFlush;
    logic [31:0]      oPC;
    logic [31:0]      oPCPlus4;
    logic [31:0]      oDecPC;
    logic             oDecValid;
    logic [CNT_W-1:0] oRedirectCnt;
`ifdef PC_MISALIGN_TRAP_EN
    logic             oMisaligned;
`endif

    modport master (
        output iPCsrc, iImmExt, iStall, iFlush,
        input  oPC, oPCPlus4, oDecPC, oDecValid, oRedirectCnt
`ifdef PC_MISALIGN_TRAP_EN
        , input oMisaligned
`endif
    );

    modport slave (
        input  iPCsrc, iImmExt, iStall, iFlush,
        output oPC, oPCPlus4, oDecPC, oDecValid, oRedirectCnt
`ifdef PC_MISALIGN_TRAP_EN
        , output oMisaligned
`endif
    );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: hold, branch target, or sequential.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned targets go to TRAP_VEC).
module pc_next_sel
    import pc_fetch_pkg::*;
`ifdef PC_MISALIGN_TRAP_EN
#(
    parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
)
`endif
(
    input  logic [31:0] pc,
    input  logic [31:0] dec_pc,
    input  logic [31:0] imm_ext,
    input  logic        pc_src,
    input  logic        dec_valid,
    input  logic        stall,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4,
    output logic        redirect
`ifdef PC_MISALIGN_TRAP_EN
    , output logic      misaligned
`endif
);

    logic [31:0] target;

    // Target is relative to the instruction in decode; a stall freezes everything.
    always_comb begin
        target   = dec_pc + imm_ext;
        pc_plus4 = pc + 32'(INSTR_BYTES);
        redirect = pc_src & dec_valid & ~stall;
        next_pc  = pc_plus4;
`ifdef PC_MISALIGN_TRAP_EN
        misaligned = 1'b0;
`endif
        if (stall) begin
            next_pc = pc;
        end else if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (target[1:0] != 2'b00) begin
                next_pc    = TRAP_VEC;
                misaligned = 1'b1;
            end else begin
                next_pc = target;
            end
`else
            next_pc = target & ~32'h0000_0003;
`endif
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: program counter, fetch/decode register, and saturating redirect counter.
// Optional feature macro: PC_MISALIGN_TRAP_EN (trap on misaligned redirect target).
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned CNT_W    = 16
`ifdef PC_MISALIGN_TRAP_EN
    , parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
`endif
) (
    input  logic     iClk,
    input  logic     iRst,
    pc_fetch_if.slave bus
);

    logic [31:0]      pc;
    fetch_dec_t       fd;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      next_pc;
    logic [31:0]      pc_plus4;
    logic             redirect;
`ifdef PC_MISALIGN_TRAP_EN
    logic             sel_misaligned;
    logic             misaligned;
`endif

    pc_next_sel
`ifdef PC_MISALIGN_TRAP_EN
    #(.TRAP_VEC(TRAP_VEC))
`endif
    u_next_sel (
        .pc        (pc),
        .dec_pc    (fd.pc),
        .imm_ext   (bus.iImmExt),
        .pc_src    (bus.iPCsrc),
        .dec_valid (fd.valid),
        .stall     (bus.iStall),
        .next_pc   (next_pc),
        .pc_plus4  (pc_plus4),
        .redirect  (redirect)
`ifdef PC_MISALIGN_TRAP_EN
        , .misaligned (sel_misaligned)
`endif
    );

    // State update: stall holds (flush still kills valid), redirect squashes, else advance.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            pc  <= RESET_PC;
            fd  <= '0;
            cnt <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
        end else begin
            pc <= next_pc;
`ifdef PC_MISALIGN_TRAP_EN
            misaligned <= sel_misaligned;
`endif
            if (bus.iStall) begin
                fd.valid <= fd.valid & ~bus.iFlush;
            end else if (redirect) begin
                fd.pc    <= pc;
                fd.valid <= 1'b0;
                if (cnt != '1) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                fd.pc    <= pc;
                fd.valid <= ~bus.iFlush;
            end
        end
    end

    assign bus.oPC          = pc;
    assign bus.oPCPlus4     = pc_plus4;
    assign bus.oDecPC       = fd.pc;
    assign bus.oDecValid    = fd.valid;
    assign bus.oRedirectCnt = cnt;
`ifdef PC_MISALIGN_TRAP_EN
    assign bus.oMisaligned  = misaligned;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch (CNT_W=2 so counter saturation is reachable quickly).
// Optional feature macro: PC_MISALIGN_TRAP_EN selects the expected misalign behaviour.
module tb_pc_fetch;

    logic iClk = 1'b0;
    logic iRst;
    int   checks = 0;
    int   errors = 0;

    pc_fetch_if #(.CNT_W(2)) bus ();

    pc_fetch #(.CNT_W(2)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    always #5 iClk = ~iClk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] dec,
                             input logic v, input logic [31:0] cnt);
        chk({tag, ".pc"},  bus.oPC, pc);
        chk({tag, ".dec"}, bus.oDecPC, dec);
        chk({tag, ".val"}, 32'(bus.oDecValid), 32'(v));
        chk({tag, ".cnt"}, 32'(bus.oRedirectCnt), cnt);
    endtask

    task automatic step;
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input logic src, input logic [31:0] imm, input logic st, input logic fl);
        bus.iPCsrc  = src;
        bus.iImmExt = imm;
        bus.iStall  = st;
        bus.iFlush  = fl;
    endtask

    initial begin
        iRst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk_state("reset", 32'h0, 32'h0, 1'b0, 0);
        chk("reset.plus4", bus.oPCPlus4, 32'h4);
`ifdef PC_MISALIGN_TRAP_EN
        chk("reset.mis", 32'(bus.oMisaligned), 0);
`endif
        step();
        chk_state("reset_held", 32'h0, 32'h0, 1'b0, 0);
        iRst = 1'b0;

        // Reset release: sequential fetch, decode lags by one.
        step(); chk_state("seq1", 32'h4, 32'h0, 1'b1, 0);
        step(); chk_state("seq2", 32'h8, 32'h4, 1'b1, 0);
        step(); chk_state("seq3", 32'hC, 32'h8, 1'b1, 0);

        // Taken branch from decode PC 8 with offset -8.
        drive(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
        step(); chk_state("br_taken", 32'h0, 32'hC, 1'b0, 1);
`ifdef PC_MISALIGN_TRAP_EN
        chk("br_taken.mis", 32'(bus.oMisaligned), 0);
`endif
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk_state("br_target", 32'h4, 32'h0, 1'b1, 1);

        // Stall with branch pending: frozen for 2 cycles, then redirect once.
        drive(1'b1, 32'h20, 1'b1, 1'b0);
        step(); chk_state("stall1", 32'h4, 32'h0, 1'b1, 1);
        step(); chk_state("stall2", 32'h4, 32'h0, 1'b1, 1);
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        step(); chk_state("stall_rel", 32'h20, 32'h4, 1'b0, 2);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk_state("stall_tgt", 32'h24, 32'h20, 1'b1, 2);

        // Flush during stall kills valid; following iPCsrc is ignored.
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        step(); chk_state("flush_stall", 32'h24, 32'h20, 1'b0, 2);
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        step(); chk_state("ignored_src", 32'h28, 32'h24, 1'b1, 2);

        // Redirect together with flush: redirect wins, valid 0.
        drive(1'b1, 32'h8, 1'b0, 1'b1);
        step(); chk_state("br_flush", 32'h2C, 32'h28, 1'b0, 3);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk_state("br_flush_tgt", 32'h30, 32'h2C, 1'b1, 3);

        // Saturation: redirects 4 and 5 keep the 2-bit counter at 3.
        drive(1'b1, 32'h0, 1'b0, 1'b0);
        step(); chk_state("sat4", 32'h2C, 32'h30, 1'b0, 3);
        step(); chk_state("sat_bubble", 32'h30, 32'h2C, 1'b1, 3);
        step(); chk_state("sat5", 32'h2C, 32'h30, 1'b0, 3);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk_state("sat_after", 32'h30, 32'h2C, 1'b1, 3);

        // Wrap: branch to FFFF_FFFC, then sequential step wraps to 0.
        drive(1'b1, 32'hFFFF_FFD0, 1'b0, 1'b0);
        step(); chk_state("to_top", 32'hFFFF_FFFC, 32'h30, 1'b0, 3);
        chk("top.plus4", bus.oPCPlus4, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step(); chk_state("wrap", 32'h0, 32'hFFFF_FFFC, 1'b1, 3);

        // Misaligned target 0x42 (decode PC FFFF_FFFC + 0x46).
        drive(1'b1, 32'h46, 1'b0, 1'b0);
        step();
`ifdef PC_MISALIGN_TRAP_EN
        chk_state("mis", 32'h100, 32'h0, 1'b0, 3);
        chk("mis.pulse", 32'(bus.oMisaligned), 1);
`else
        chk_state("mis", 32'h40, 32'h0, 1'b0, 3);
`endif
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
`ifdef PC_MISALIGN_TRAP_EN
        chk_state("mis_after", 32'h104, 32'h100, 1'b1, 3);
        chk("mis.drop", 32'(bus.oMisaligned), 0);
`else
        chk_state("mis_after", 32'h44, 32'h40, 1'b1, 3);
`endif

        // Asynchronous reset mid-cycle takes effect without a clock edge.
        #3;
        iRst = 1'b1;
        #1;
        chk_state("async_rst", 32'h0, 32'h0, 1'b0, 0);
        step();
        iRst = 1'b0;
        step(); chk_state("post_rst", 32'h4, 32'h0, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Fetch stage feeding the control unit. Holds the architectural program counter, advances it by 4 each cycle, and redirects it on a taken branch/jump signalled by the control unit. It also registers the fetched PC into a single fetch/decode register with a valid bit, and supports stall and flush. The control unit decodes the instruction at `oDecPC` and returns `iPCsrc`/`iImmExt` for it.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `TRAP_VEC`, 32'h0000_0100, redirect address for a misaligned target (only with the macro)
- `CNT_W`, 16, width of the redirect counter

- `iClk`  in  1  clock; all state updates on rising edge
- `iRst`  in  1  reset; asynchronous, active-high
- `iPCsrc`  in  1  taken branch/jump for the instruction at `oDecPC`
- `iImmExt`  in  32  sign-extended offset, relative to `oDecPC`
- `iStall`  in  1  hold PC and fetch/decode register
- `iFlush`  in  1  invalidate fetch/decode register
- `oPC`  out  32  current fetch address
- `oPCPlus4`  out  32  `oPC + 4`, combinational, for link writeback
- `oDecPC`  out  32  PC of the instruction in decode
- `oDecValid`  out  1  `oDecPC` holds a live instruction
- `oRedirectCnt`  out  CNT_W  number of taken redirects, saturating
- `oMisaligned`  out  1  one-cycle pulse on a misaligned target (macro only)

## Operation
- Target = `oDecPC + iImmExt`, modulo 2^32. Sequential PC = `oPC + 4`, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- A redirect occurs when `iPCsrc & oDecValid & ~iStall`. `iPCsrc` is ignored while `oDecValid=0`.
- Rising-edge update priority, highest first:
  1. **Reset:** see Timing.
  2. **Stall** (`iStall=1`):
     - `oPC`, `oDecPC` and `oRedirectCnt` hold.
     - `oDecValid` is cleared if `iFlush=1`, otherwise it holds. Flush dominates stall.
     - A pending branch re-evaluates once the stall drops.
  3. **Redirect:**
     - `oPC` <= target.
     - `oDecValid` <= 0, squashing the wrong-path fetch.
     - `oDecPC` <= old `oPC`, don't-care.
     - `oRedirectCnt` increments and saturates at all-ones.
  4. **Normal:** `oPC` <= `oPC+4`; `oDecPC` <= `oPC`; `oDecValid` <= `~iFlush`.
- Simultaneous redirect and `iFlush`: the redirect applies and `oDecValid` is 0.

## Timing
- Reset values:
  - `oPC` = `RESET_PC`
  - `oDecPC` = 0
  - `oDecValid` = 0
  - `oRedirectCnt` = 0
  - `oMisaligned` = 0
- Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.
- First edge after reset release: `oDecPC` = `RESET_PC`, `oDecValid` = 1, `oPC` = `RESET_PC+4`.
- Branch penalty is 1 bubble cycle.
  - Taken at edge N: the target appears on `oPC` after edge N.
  - The target instruction is valid in decode after edge N+1.
- `oPCPlus4` is combinational from `oPC`. All other outputs are registered.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined:
  - On a redirect whose target has bits [1:0] ≠ 0, `oPC` <= `TRAP_VEC` instead of the target.
  - `oMisaligned` pulses high for exactly one cycle after that edge.
  - The counter still increments.
- `PC_MISALIGN_TRAP_EN` undefined:
  - Target bits [1:0] are forced to 0.
  - `oMisaligned` is not present on the port list.
  - `TRAP_VEC` is unused.

## Structure
- Package `pc_fetch_pkg` holds:
  - `INSTR_BYTES` = 4
  - default `RESET_PC` and `TRAP_VEC` constants
  - a `fetch_dec_t` struct `{pc[31:0], valid}` for the fetch/decode register
- One sub-module, `pc_next_sel`, is combinational:
  - Inputs: `oPC`, `oDecPC`, `iImmExt`, and the redirect/stall qualifiers.
  - Outputs: next PC and the misalign flag.
- The top level holds the registers and the counter.

## Test plan
- **Reset release:** `RESET_PC`=0, no stimulus for 3 edges.
  - `oPC` = 0 → 4 → 8 → C.
  - `oDecPC` lags `oPC` by one step.
  - `oDecValid` = 1 from the first edge.
- **Taken branch:** `oDecPC`=8, `iImmExt`=32'hFFFF_FFF8, `iPCsrc`=1 for one cycle.
  - Next `oPC` = 0 and `oDecValid` = 0.
  - The edge after that gives `oDecPC` = 0 with `oDecValid` = 1.
  - `oRedirectCnt` = 1.
- **Stall with branch pending:** `iStall`=1 for 2 cycles with `iPCsrc`=1.
  - PC and decode state are frozen and there is no redirect.
  - On stall release the redirect happens once.
- **Flush during stall:** `iStall`=1 and `iFlush`=1.
  - `oDecValid` goes to 0 while `oPC` holds.
  - `iPCsrc`=1 next cycle is ignored.
- **Wrap and saturation:**
  - `oPC` = 32'hFFFF_FFFC advances to 0.
  - With `CNT_W`=2, 5 redirects give `oRedirectCnt` = 3.
- **`PC_MISALIGN_TRAP_EN` defined:** target 32'h0000_0042.
  - `oPC` = 32'h100 and `oMisaligned` is high for exactly 1 cycle.
  - With the macro undefined, `oPC` = 32'h40.
